mem_access_seq: RTL and testbench

MEM_ACCESS_SEQ -- requirements
Module: mem_access_seq

---
 rtl/mem_access_seq_pkg.sv | 25 ++
 rtl/mem_access_seq_if.sv | 23 ++
 rtl/mem_access_seq_timer.sv | 30 +++
 rtl/mem_access_seq.sv | 151 +++++++++++++++
 tb/tb_mem_access_seq.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_seq_pkg.sv
// Shared types and constants for the memory access sequencer: FSM states,
// fault cause codes and the default abort timeout.
package mem_access_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_REQ  = 3'd1,
    ST_WAIT = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ALIGN   = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_BOUNDS  = 2'b11;

  localparam int DEF_TIMEOUT_CYC = 16;

  // Word accesses only: any non-zero byte offset is rejected.
  function automatic logic misaligned(input logic [1:0] lsb);
    return (lsb != 2'b00);
  endfunction

endpackage

// File: rtl/mem_access_seq_if.sv
// Memory request/response bus between the access sequencer (master) and the
// data memory (slave).
interface mem_access_seq_if #(
  parameter int AW = 32
);
  logic          req_o;
  logic          we_o;
  logic [AW-1:0] addr_o;
  logic [31:0]   wdata_o;
  logic          gnt_i;
  logic          rvalid_i;
  logic [31:0]   rdata_i;

  modport master (
    output req_o, we_o, addr_o, wdata_o,
    input  gnt_i, rvalid_i, rdata_i
  );

  modport slave (
    input  req_o, we_o, addr_o, wdata_o,
    output gnt_i, rvalid_i, rdata_i
  );
endinterface

// File: rtl/mem_access_seq_timer.sv
// Saturating cycle counter used to abort memory accesses that take too long;
// expired is asserted in the enabled cycle that brings the count to LIMIT.
module mem_access_timer #(
  parameter int LIMIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] count_r;

  // Count enabled cycles, restart on clear, hold once the limit is reached.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable && (count_r != CW'(LIMIT))) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = enable && (count_r == CW'(LIMIT - 1));
endmodule

// File: rtl/mem_access_seq.sv
// Load/store access sequencer: stalls the core while a single word access runs
// on the memory bus. Optional capability bounds check: CAP_BOUNDS_CHECK_EN.
module mem_access_seq
  import mem_access_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int AW          = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [31:0]       wdata_i,
  input  logic [AW-1:0]     cap_base_i,
  input  logic [AW-1:0]     cap_top_i,
  output logic              stall_o,
  output logic              done_o,
  output logic [31:0]       rdata_o,
  output logic              fault_o,
  output logic [1:0]        err_code_o,
  mem_access_seq_if.master  mem
);

  state_t        state_r, state_next_s;
  logic [1:0]    err_next_s, err_code_r;
  logic          req_r, we_r, done_r, fault_r;
  logic [AW-1:0] addr_r;
  logic [31:0]   wdata_r, rdata_r;
  logic          capture_s, rcap_s, tmr_clear_s, tmr_en_s, tmr_expired_s;
  logic          bounds_bad_s;

`ifdef CAP_BOUNDS_CHECK_EN
  localparam int AWP = AW + 1;
  logic [AW:0] acc_end_s;
  // Compare with one spare bit so addr_i + 4 cannot wrap past the top.
  assign acc_end_s    = {1'b0, addr_i} + AWP'(32'd4);
  assign bounds_bad_s = (addr_i < cap_base_i) || (acc_end_s > {1'b0, cap_top_i});
`else
  logic cap_unused_s;
  assign cap_unused_s = ^{cap_base_i, cap_top_i};
  assign bounds_bad_s = 1'b0;
`endif

  mem_access_timer #(.LIMIT(TIMEOUT_CYC)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (tmr_clear_s),
    .enable  (tmr_en_s),
    .expired (tmr_expired_s)
  );

  // Next-state and control decode.
  always_comb begin
    state_next_s = state_r;
    err_next_s   = ERR_NONE;
    capture_s    = 1'b0;
    rcap_s       = 1'b0;
    tmr_clear_s  = 1'b0;
    tmr_en_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!(mem_read_i || mem_write_i)) begin
          state_next_s = ST_IDLE;
        end else if ((mem_read_i && mem_write_i) || misaligned(addr_i[1:0])) begin
          state_next_s = ST_ERR;
          err_next_s   = ERR_ALIGN;
        end else if (bounds_bad_s) begin
          state_next_s = ST_ERR;
          err_next_s   = ERR_BOUNDS;
        end else begin
          state_next_s = ST_REQ;
          capture_s    = 1'b1;
          tmr_clear_s  = 1'b1;
        end
      end
      ST_REQ: begin
        tmr_en_s = 1'b1;
        if (mem.gnt_i) begin
          state_next_s = we_r ? ST_DONE : ST_WAIT;
        end else if (tmr_expired_s) begin
          state_next_s = ST_ERR;
          err_next_s   = ERR_TIMEOUT;
        end else begin
          state_next_s = ST_REQ;
        end
      end
      ST_WAIT: begin
        tmr_en_s = 1'b1;
        if (mem.rvalid_i) begin
          state_next_s = ST_DONE;
          rcap_s       = 1'b1;
        end else if (tmr_expired_s) begin
          state_next_s = ST_ERR;
          err_next_s   = ERR_TIMEOUT;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      ST_ERR:  state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State register plus registered bus and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      req_r      <= 1'b0;
      we_r       <= 1'b0;
      addr_r     <= '0;
      wdata_r    <= 32'h0000_0000;
      rdata_r    <= 32'h0000_0000;
      done_r     <= 1'b0;
      fault_r    <= 1'b0;
      err_code_r <= ERR_NONE;
    end else begin
      state_r    <= state_next_s;
      req_r      <= (state_next_s == ST_REQ);
      done_r     <= (state_next_s == ST_DONE);
      fault_r    <= (state_next_s == ST_ERR);
      err_code_r <= err_next_s;
      if (capture_s) begin
        we_r    <= mem_write_i;
        addr_r  <= addr_i;
        wdata_r <= wdata_i;
      end else begin
        we_r    <= we_r;
        addr_r  <= addr_r;
        wdata_r <= wdata_r;
      end
      if (rcap_s) begin
        rdata_r <= mem.rdata_i;
      end else begin
        rdata_r <= rdata_r;
      end
    end
  end

  assign mem.req_o   = req_r;
  assign mem.we_o    = we_r;
  assign mem.addr_o  = addr_r;
  assign mem.wdata_o = wdata_r;

  assign stall_o    = (mem_read_i || mem_write_i) && (state_r != ST_DONE) && (state_r != ST_ERR);
  assign done_o     = done_r;
  assign fault_o    = fault_r;
  assign err_code_o = err_code_r;
  assign rdata_o    = rdata_r;
endmodule

// File: tb/tb_mem_access_seq.sv
// Scoreboard bench for mem_access_seq: expectations queued by the stimulus,
// popped by a monitor on every done_o/fault_o pulse.
module tb_mem_access_seq;

  typedef struct {
    logic        is_fault;
    logic        is_read;
    logic [31:0] rdata;
    logic [1:0]  code;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_read, mem_write;
  logic [31:0] addr, wdata, cap_base, cap_top;
  logic        stall, done, fault;
  logic [31:0] rdata;
  logic [1:0]  err_code;
  int          n_total = 0;
  int          n_bad = 0;
  exp_t        sb[$];

  mem_access_seq_if #(.AW(32)) bus();

  mem_access_seq #(.TIMEOUT_CYC(16), .AW(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_read_i  (mem_read),
    .mem_write_i (mem_write),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .cap_base_i  (cap_base),
    .cap_top_i   (cap_top),
    .stall_o     (stall),
    .done_o      (done),
    .rdata_o     (rdata),
    .fault_o     (fault),
    .err_code_o  (err_code),
    .mem         (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every completion or abort pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && (done || fault)) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_pulse", {62'd0, done, fault}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("sb_fault", fault, e.is_fault);
        chk("sb_done", done, !e.is_fault);
        chk("sb_code", err_code, e.is_fault ? e.code : 2'b00);
        if (!e.is_fault && e.is_read) chk("sb_rdata", rdata, e.rdata);
      end
    end
  end

  // One access from request to completion; gdly idle REQ cycles before gnt.
  task automatic access(input string nm, input logic rd, input logic wr,
                        input logic [31:0] a, input logic [31:0] wd, input int gdly,
                        input logic [31:0] rdv, input logic [1:0] ecode);
    exp_t e;
    e.is_fault = (ecode != 2'b00);
    e.is_read  = rd && !wr;
    e.rdata    = rdv;
    e.code     = ecode;
    sb.push_back(e);
    mem_read = rd; mem_write = wr; addr = a; wdata = wd;
    #1;
    chk({nm, "_stall_c1"}, stall, 1'b1);
    chk({nm, "_req_c1"}, bus.req_o, 1'b0);
    tick();
    if (e.is_fault) begin
      chk({nm, "_fault"}, fault, 1'b1);
      chk({nm, "_code"}, err_code, ecode);
      chk({nm, "_req_err"}, bus.req_o, 1'b0);
      chk({nm, "_stall_err"}, stall, 1'b0);
      mem_read = 1'b0; mem_write = 1'b0;
      tick();
      chk({nm, "_req_after"}, bus.req_o, 1'b0);
      return;
    end
    addr  = a ^ 32'h0000_0100;
    wdata = ~wd;
    for (int i = 0; i < gdly; i++) begin
      chk({nm, "_req_hold"}, bus.req_o, 1'b1);
      chk({nm, "_addr_hold"}, bus.addr_o, a);
      chk({nm, "_we_hold"}, bus.we_o, wr);
      if (wr) chk({nm, "_wdata_hold"}, bus.wdata_o, wd);
      chk({nm, "_done_early"}, done, 1'b0);
      tick();
    end
    bus.gnt_i = 1'b1;
    chk({nm, "_req_gnt"}, bus.req_o, 1'b1);
    chk({nm, "_addr_gnt"}, bus.addr_o, a);
    chk({nm, "_stall_gnt"}, stall, 1'b1);
    tick();
    bus.gnt_i = 1'b0;
    if (rd) begin
      bus.rvalid_i = 1'b1;
      bus.rdata_i  = rdv;
      chk({nm, "_req_wait"}, bus.req_o, 1'b0);
      chk({nm, "_done_wait"}, done, 1'b0);
      chk({nm, "_stall_wait"}, stall, 1'b1);
      tick();
      bus.rvalid_i = 1'b0;
      bus.rdata_i  = 32'h0000_0000;
    end
    chk({nm, "_done"}, done, 1'b1);
    chk({nm, "_stall_done"}, stall, 1'b0);
    if (rd) chk({nm, "_rdata"}, rdata, rdv);
    mem_read = 1'b0; mem_write = 1'b0;
    tick();
    chk({nm, "_done_1cyc"}, done, 1'b0);
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    addr = 32'h0; wdata = 32'h0; cap_base = 32'h0000_1000; cap_top = 32'h0000_1010;
    bus.gnt_i = 1'b0; bus.rvalid_i = 1'b0; bus.rdata_i = 32'h0;
    #12;
    chk("rst_req", bus.req_o, 1'b0);
    chk("rst_we", bus.we_o, 1'b0);
    chk("rst_addr", bus.addr_o, 32'h0);
    chk("rst_wdata", bus.wdata_o, 32'h0);
    chk("rst_done_fault", {done, fault}, 2'b00);
    chk("rst_err", err_code, 2'b00);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_stall", stall, 1'b0);
    rst_n = 1'b1;
    tick();

    access("rd100", 1'b1, 1'b0, 32'h0000_0100, 32'h0, 0, 32'hDEAD_BEEF, 2'b00);
    chk("rdata_retain", rdata, 32'hDEAD_BEEF);
    access("wr200", 1'b0, 1'b1, 32'h0000_0200, 32'h1234_5678, 3, 32'h0, 2'b00);
    chk("rdata_after_wr", rdata, 32'hDEAD_BEEF);
    access("misal", 1'b1, 1'b0, 32'h0000_0102, 32'h0, 0, 32'h0, 2'b01);
    access("both", 1'b1, 1'b1, 32'h0000_0040, 32'h0, 0, 32'h0, 2'b01);
    access("rd_slow", 1'b1, 1'b0, 32'h0000_0ABC, 32'h0, 2, 32'h5A5A_0F0F, 2'b00);

    // Stray rvalid while idle must not disturb anything.
    bus.rvalid_i = 1'b1; bus.rdata_i = 32'h1111_2222;
    tick();
    bus.rvalid_i = 1'b0;
    chk("stray_rvalid_rdata", rdata, 32'h5A5A_0F0F);
    chk("stray_rvalid_done", done, 1'b0);

    // Read with no grant: abort after 16 REQ cycles.
    e.is_fault = 1'b1; e.is_read = 1'b1; e.rdata = 32'h0; e.code = 2'b10;
    sb.push_back(e);
    mem_read = 1'b1; addr = 32'h0000_0104;
    tick();
    for (int i = 0; i < 16; i++) begin
      chk("to_req", bus.req_o, 1'b1);
      chk("to_no_fault", fault, 1'b0);
      tick();
    end
    chk("to_fault", fault, 1'b1);
    chk("to_code", err_code, 2'b10);
    chk("to_req_low", bus.req_o, 1'b0);
    mem_read = 1'b0;
    tick();
    chk("to_fault_1cyc", fault, 1'b0);
    chk("to_rdata", rdata, 32'h5A5A_0F0F);

`ifdef CAP_BOUNDS_CHECK_EN
    access("cap_ok", 1'b1, 1'b0, 32'h0000_100C, 32'h0, 0, 32'h0BAD_CAFE, 2'b00);
    access("cap_top", 1'b1, 1'b0, 32'h0000_1010, 32'h0, 0, 32'h0, 2'b11);
    access("cap_base", 1'b0, 1'b1, 32'h0000_0FFC, 32'h7, 0, 32'h0, 2'b11);
`else
    access("nocap_top", 1'b1, 1'b0, 32'h0000_1010, 32'h0, 0, 32'h0BAD_CAFE, 2'b00);
    access("nocap_base", 1'b0, 1'b1, 32'h0000_0FFC, 32'h7, 1, 32'h0, 2'b00);
`endif

    // Reset in WAIT; the late rvalid must be ignored.
    mem_read = 1'b1; addr = 32'h0000_0180;
    tick();
    bus.gnt_i = 1'b1;
    tick();
    bus.gnt_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_req", bus.req_o, 1'b0);
    chk("mid_rst_rdata", rdata, 32'h0);
    mem_read = 1'b0;
    #1;
    rst_n = 1'b1;
    tick();
    bus.rvalid_i = 1'b1; bus.rdata_i = 32'hCAFE_F00D;
    tick();
    bus.rvalid_i = 1'b0;
    chk("late_rvalid_done", done, 1'b0);
    chk("late_rvalid_rdata", rdata, 32'h0);
    chk("late_rvalid_req", bus.req_o, 1'b0);
    tick();
    chk("late_rvalid_done2", done, 1'b0);

    repeat (3) tick();
    chk("sb_empty", sb.size(), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
